// File: rtl/mmio_sw_led.sv
// Bus-side switch/LED responder: a four-word register window holding the LEDs,
// the debounced switches, a sticky change flag and its interrupt enable.
module mmio_sw_led #(
    parameter logic [15:0] BASE_ADDR = 16'hC000,
    parameter int          DB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rvalid,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR,
    output logic        irq
);

    localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

    logic [9:0]  s1;
    logic [9:0]  s2;
    logic [9:0]  sw_db;
    logic [7:0]  cnt;
    logic        pend;
    logic        ien;

    logic        in_window;
    logic [1:0]  offset;
    logic        wr_en;
    logic        rd_en;
    logic        db_done;
    logic        pend_clr;
    logic [15:0] rd_value;
    logic        unused_wdata_bits;

    assign in_window = (addr[15:2] == BASE_ADDR[15:2]);
    assign offset    = addr[1:0];
    assign wr_en     = we && in_window;
    // A simultaneous write takes priority and silently drops the read.
    assign rd_en     = re && !we;
    assign db_done   = (s2 != sw_db) && (cnt == CNT_LAST);
    assign pend_clr  = wr_en && (offset == 2'd2) && wdata[0];
    assign unused_wdata_bits = ^wdata[15:10];

    always_comb begin
        rd_value = 16'h0000;
        if (in_window) begin
            case (offset)
                2'd0:    rd_value = {6'b0, LEDR};
                2'd1:    rd_value = {6'b0, sw_db};
                2'd2:    rd_value = {15'b0, pend};
                default: rd_value = {15'b0, ien};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            sw_db  <= '0;
            cnt    <= '0;
            pend   <= 1'b0;
            ien    <= 1'b0;
            LEDR   <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            irq    <= 1'b0;
        end else begin
            s1 <= SW;
            s2 <= s1;

            // Any return of s2 to the accepted value restarts the stability count.
            if (s2 == sw_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                sw_db <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end

            if (db_done) begin
                pend <= 1'b1;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end

            if (wr_en && offset == 2'd0) begin
                LEDR <= wdata[9:0];
            end
            if (wr_en && offset == 2'd3) begin
                ien <= wdata[0];
            end

            rvalid <= rd_en;
            if (rd_en) begin
                rdata <= rd_value;
            end

            irq <= pend && ien;
        end
    end

endmodule

// File: tb/tb_mmio_sw_led.sv
// Directed bench for mmio_sw_led: inputs change and outputs are sampled on the
// falling edge, so every task step spans exactly one rising edge.
module tb_mmio_sw_led;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rvalid;
    logic [9:0]  SW;
    logic [9:0]  LEDR;
    logic        irq;

    int errors;
    int checks;

    mmio_sw_led #(.BASE_ADDR(16'hC000), .DB_CYCLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .re     (re),
        .we     (we),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .SW     (SW),
        .LEDR   (LEDR),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [15:0] d, output logic v);
        addr = a;
        re   = 1'b1;
        @(negedge clk);
        re = 1'b0;
        d  = rdata;
        v  = rvalid;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        v;
        rst = 1'b1;
        SW  = 10'h3FF;
        idle(2);
        checks++; if (LEDR !== 10'h000) begin errors++; $display("[TB] FAIL reset_ledr: got %h expected 000", LEDR); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0000", rdata); end
        rst = 1'b0;
        do_read(16'hC001, d, v);
        checks++; if (d !== 16'h0000 || v !== 1'b1) begin errors++; $display("[TB] FAIL reset_sw_early1: got %h/%b expected 0000/1", d, v); end
        do_read(16'hC001, d, v);
        checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sw_early2: got %h expected 0000", d); end
        idle(4);
        do_read(16'hC001, d, v);
        checks++; if (d !== 16'h03FF) begin errors++; $display("[TB] FAIL reset_sw_settled: got %h expected 03ff", d); end
    endtask

    task automatic test_led();
        logic [15:0] d;
        logic        v;
        do_write(16'hC000, 16'hFFFF);
        checks++; if (LEDR !== 10'h3FF) begin errors++; $display("[TB] FAIL led_write: got %h expected 3ff", LEDR); end
        do_read(16'hC000, d, v);
        checks++; if (d !== 16'h03FF || v !== 1'b1) begin errors++; $display("[TB] FAIL led_read: got %h/%b expected 03ff/1", d, v); end
        idle(1);
        checks++; if (rvalid !== 1'b0 || rdata !== 16'h03FF) begin errors++; $display("[TB] FAIL led_hold: got %h/%b expected 03ff/0", rdata, rvalid); end
    endtask

    task automatic test_debounce();
        logic [15:0] d;
        logic        v;
        logic [15:0] exp;
        do_write(16'hC002, 16'h0001);
        SW   = 10'h2A5;
        addr = 16'hC001;
        re   = 1'b1;
        // Reads sampled at edges K..K+5 still see the old value; K+6 sees the new one.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            exp = (i < 6) ? 16'h03FF : 16'h02A5;
            checks++; if (rdata !== exp || rvalid !== 1'b1) begin errors++; $display("[TB] FAIL debounce_edge%0d: got %h/%b expected %h/1", i, rdata, rvalid, exp); end
        end
        re = 1'b0;
        do_read(16'hC002, d, v);
        checks++; if (d !== 16'h0001) begin errors++; $display("[TB] FAIL debounce_pend: got %h expected 0001", d); end
    endtask

    task automatic test_mirror();
        logic [15:0] d;
        logic        v;
        int          cycles;
        rst = 1'b1;
        SW  = 10'h155;
        idle(1);
        rst    = 1'b0;
        cycles = 0;
        for (int i = 0; i < 10; i++) begin
            do_read(16'hC001, d, v);
            do_write(16'hC000, d);
            cycles += 2;
            if (LEDR === SW) break;
        end
        checks++; if (LEDR !== 10'h155) begin errors++; $display("[TB] FAIL mirror_value: got %h expected 155", LEDR); end
        checks++; if (cycles > 15) begin errors++; $display("[TB] FAIL mirror_latency: got %0d cycles expected <= 15", cycles); end
    endtask

    task automatic test_glitch();
        logic [15:0] d;
        logic        v;
        rst = 1'b1;
        SW  = 10'h000;
        idle(1);
        rst = 1'b0;
        SW  = 10'h001;
        idle(3);
        SW = 10'h000;
        idle(8);
        do_read(16'hC001, d, v);
        checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL glitch_sw: got %h expected 0000", d); end
        do_read(16'hC002, d, v);
        checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL glitch_pend: got %h expected 0000", d); end
    endtask

    task automatic test_irq();
        logic [15:0] d;
        logic        v;
        do_write(16'hC003, 16'h0001);
        do_read(16'hC003, d, v);
        checks++; if (d !== 16'h0001) begin errors++; $display("[TB] FAIL irq_ien_read: got %h expected 0001", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_idle: got %b expected 0", irq); end
        SW = 10'h0F0;
        idle(8);
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_raise: got %b expected 1", irq); end
        do_read(16'hC002, d, v);
        checks++; if (d !== 16'h0001) begin errors++; $display("[TB] FAIL irq_pend: got %h expected 0001", d); end
        do_write(16'hC002, 16'h0001);
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_clear_lag: got %b expected 1", irq); end
        idle(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_cleared: got %b expected 0", irq); end
        // Clear lands on the same edge the debouncer accepts 0FF; the set must win.
        SW = 10'h0FF;
        idle(5);
        do_write(16'hC002, 16'h0001);
        do_read(16'hC002, d, v);
        checks++; if (d !== 16'h0001) begin errors++; $display("[TB] FAIL irq_set_wins: got %h expected 0001", d); end
        do_read(16'hC001, d, v);
        checks++; if (d !== 16'h00FF) begin errors++; $display("[TB] FAIL irq_sw_value: got %h expected 00ff", d); end
    endtask

    task automatic test_corner();
        logic [15:0] d;
        logic        v;
        addr  = 16'hC000;
        wdata = 16'h0123;
        re    = 1'b1;
        we    = 1'b1;
        @(negedge clk);
        re = 1'b0;
        we = 1'b0;
        checks++; if (LEDR !== 10'h123) begin errors++; $display("[TB] FAIL corner_rw_write: got %h expected 123", LEDR); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL corner_rw_noread: got %b expected 0", rvalid); end
        do_read(16'hC000, d, v);
        checks++; if (d !== 16'h0123) begin errors++; $display("[TB] FAIL corner_led_read: got %h expected 0123", d); end
        do_read(16'h1234, d, v);
        checks++; if (d !== 16'h0000 || v !== 1'b1) begin errors++; $display("[TB] FAIL corner_outside_read: got %h/%b expected 0000/1", d, v); end
        do_write(16'hC001, 16'h0000);
        do_read(16'hC001, d, v);
        checks++; if (d !== 16'h00FF) begin errors++; $display("[TB] FAIL corner_sw_ro: got %h expected 00ff", d); end
        do_write(16'hC002, 16'h0000);
        do_read(16'hC002, d, v);
        checks++; if (d !== 16'h0001) begin errors++; $display("[TB] FAIL corner_w0_status: got %h expected 0001", d); end
        do_write(16'h1000, 16'h03FF);
        checks++; if (LEDR !== 10'h123) begin errors++; $display("[TB] FAIL corner_outside_write: got %h expected 123", LEDR); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic        v;
        addr = 16'hC000;
        re   = 1'b1;
        rst  = 1'b1;
        @(negedge clk);
        re  = 1'b0;
        rst = 1'b0;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rvalid: got %b expected 0", rvalid); end
        checks++; if (LEDR !== 10'h000 || irq !== 1'b0) begin errors++; $display("[TB] FAIL midrst_state: got %h/%b expected 000/0", LEDR, irq); end
        do_read(16'hC003, d, v);
        checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_ien: got %h expected 0000", d); end
        do_read(16'hC002, d, v);
        checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_pend: got %h expected 0000", d); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        addr   = 16'h0000;
        re     = 1'b0;
        we     = 1'b0;
        wdata  = 16'h0000;
        SW     = 10'h000;
        @(negedge clk);
        test_reset();
        test_led();
        test_debounce();
        test_mirror();
        test_glitch();
        test_irq();
        test_corner();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
